// File: rtl/protocol_pkg.sv
// Shared types and defaults for the voice scheduler and its oscillator/front-end neighbours.
package protocol_pkg;

  localparam int N_OSCILLATORS      = 8;
  localparam int FIXED_POINT        = 8;
  localparam int VOICE_GRACE        = 31;
  localparam int ENVELOPE_RESET_BIT = 0;
  localparam int DEFAULT_WIDTH      = 24;

  typedef enum logic [1:0] {
    WAVE_SINE,
    WAVE_SQUARE,
    WAVE_SAW,
    WAVE_TRIANGLE
  } wave_shape;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } sched_state_t;

  typedef struct packed {
    logic [31:0]              freq;
    logic [DEFAULT_WIDTH-1:0] amp;
    wave_shape                shape;
  } voice_cfg_t;

endpackage

// File: rtl/voice_scheduler_if.sv
// Note-request handshake plus the time-multiplexed oscillator bus.
interface voice_scheduler_if
  import protocol_pkg::*;
#(
  parameter int N_VOICES = N_OSCILLATORS,
  parameter int WIDTH    = DEFAULT_WIDTH
);

  localparam int IW = $clog2(N_VOICES + 1);
  localparam int OW = WIDTH + FIXED_POINT;

  logic                 note_valid;
  logic                 note_ready;
  logic [31:0]          note_freq;
  logic [WIDTH-1:0]     note_amp;
  wave_shape            note_shape;

  logic [IW-1:0]        index;
  logic [31:0]          freq;
  logic [WIDTH-1:0]     amplitude;
  wave_shape            shape;
  logic [7:0]           cmds;
  logic                 osc_enable;
  logic signed [OW-1:0] osc_out;
  logic                 osc_enabled;

  // master is the scheduler: it answers note requests and drives the oscillator.
  modport master (
    input  note_valid, note_freq, note_amp, note_shape, osc_out, osc_enabled,
    output note_ready, index, freq, amplitude, shape, cmds, osc_enable
  );

  modport slave (
    output note_valid, note_freq, note_amp, note_shape, osc_out, osc_enabled,
    input  note_ready, index, freq, amplitude, shape, cmds, osc_enable
  );

endinterface

// File: rtl/voice_allocator.sv
// Picks the lowest free voice, or the round-robin steal victim when every voice is busy.
module voice_allocator #(
  parameter int N_VOICES = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [N_VOICES-1:0]         busy_i,
  input  logic                        alloc_i,
  output logic [$clog2(N_VOICES)-1:0] voice_o,
  output logic                        steal_o
);

  localparam int VW = $clog2(N_VOICES);

  logic [VW-1:0] steal_q, steal_d;

  // NOTE: every output of a combinational block gets a default before any branch, so no latch is inferred.
  always_comb begin
    steal_o = &busy_i;
    voice_o = steal_q;
    // Descending scan so the last hit, the lowest free voice, wins.
    for (int v = N_VOICES - 1; v >= 0; v--) begin
      if (!busy_i[v]) voice_o = VW'(v);
    end
  end

  always_comb begin
    steal_d = steal_q;
    if (alloc_i && steal_o) begin
      steal_d = (steal_q == VW'(N_VOICES - 1)) ? '0 : steal_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) steal_q <= '0;
    else       steal_q <= steal_d;
  end

endmodule

// File: rtl/voice_scheduler.sv
// Sweeps the shared oscillator across all voices once per sample, mixes the results,
// and allocates incoming note-on requests to voices.
module voice_scheduler
  import protocol_pkg::*;
#(
  parameter int N_VOICES = N_OSCILLATORS,
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int GRACE    = VOICE_GRACE
) (
  input  logic                                                  clk,
  input  logic                                                  rstn,
  input  logic                                                  sample_tick,
  voice_scheduler_if.master                                     bus,
  output logic signed [WIDTH+FIXED_POINT+$clog2(N_VOICES)-1:0]  mix_out,
  output logic                                                  mix_valid,
  output logic                                                  overrun
);

  localparam int IW = $clog2(N_VOICES + 1);
  localparam int VW = $clog2(N_VOICES);
  localparam int OW = WIDTH + FIXED_POINT;
  localparam int MW = OW + VW;
  localparam int GW = $clog2(GRACE + 1);

  localparam logic [IW-1:0] PARKED = IW'(N_VOICES);
  localparam logic [IW-1:0] LAST   = IW'(N_VOICES - 1);

  typedef struct packed {
    logic [31:0]      freq;
    logic [WIDTH-1:0] amp;
    wave_shape        shape;
  } cfg_t;

  sched_state_t         state_q;
  logic [IW-1:0]        index_q;
  logic signed [MW-1:0] acc_q;
  logic signed [MW-1:0] mix_out_q;
  logic                 mix_valid_q;
  logic                 overrun_q;
  logic                 osc_enable_q;

  cfg_t                 cfg_q     [N_VOICES];
  logic [GW-1:0]        grace_q   [N_VOICES];
  logic [N_VOICES-1:0]  busy_q;
  logic [N_VOICES-1:0]  pending_q;

  logic [VW-1:0]        sel;
  logic                 sweeping;
  logic                 accept;
  logic [VW-1:0]        alloc_voice;
  logic                 alloc_steal_unused;
  logic signed [MW-1:0] osc_ext;

  assign sel      = (index_q < PARKED) ? index_q[VW-1:0] : '0;
  assign sweeping = (state_q == SWEEP);
  assign accept   = bus.note_valid && (state_q == IDLE);
  assign osc_ext  = {{VW{bus.osc_out[OW-1]}}, bus.osc_out};

  // The chosen voice already accounts for stealing; the flag is not needed here.
  voice_allocator #(
    .N_VOICES (N_VOICES)
  ) u_alloc (
    .clk     (clk),
    .rstn    (rstn),
    .busy_i  (busy_q),
    .alloc_i (accept),
    .voice_o (alloc_voice),
    .steal_o (alloc_steal_unused)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      index_q      <= PARKED;
      acc_q        <= '0;
      mix_out_q    <= '0;
      mix_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      osc_enable_q <= 1'b0;
    end else begin
      osc_enable_q <= 1'b1;
      mix_valid_q  <= 1'b0;
      if (sample_tick && (state_q != IDLE)) overrun_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (sample_tick) begin
            state_q <= SWEEP;
            index_q <= '0;
            acc_q   <= '0;
          end
        end
        SWEEP: begin
          acc_q   <= acc_q + osc_ext;
          index_q <= index_q + 1'b1;
          if (index_q == LAST) state_q <= DONE;
        end
        DONE: begin
          mix_out_q   <= acc_q + osc_ext;
          mix_valid_q <= 1'b1;
          index_q     <= PARKED;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the voice table is reset so a freshly reset part never sweeps stale parameters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int v = 0; v < N_VOICES; v++) begin
        cfg_q[v]   <= '0;
        grace_q[v] <= '0;
      end
      busy_q    <= '0;
      pending_q <= '0;
    end else if (accept) begin
      cfg_q[alloc_voice]     <= '{freq: bus.note_freq, amp: bus.note_amp, shape: bus.note_shape};
      busy_q[alloc_voice]    <= 1'b1;
      pending_q[alloc_voice] <= 1'b1;
      grace_q[alloc_voice]   <= GW'(GRACE);
    end else if (sweeping) begin
      pending_q[sel] <= 1'b0;
      // A new voice is held busy until its envelope has had time to open.
      if (grace_q[sel] != '0) grace_q[sel] <= grace_q[sel] - 1'b1;
      else                    busy_q[sel]  <= bus.osc_enabled;
    end
  end

  always_comb begin
    bus.cmds                     = '0;
    bus.cmds[ENVELOPE_RESET_BIT] = sweeping && pending_q[sel];
  end

  assign bus.note_ready = (state_q == IDLE);
  assign bus.index      = index_q;
  assign bus.freq       = cfg_q[sel].freq;
  assign bus.amplitude  = cfg_q[sel].amp;
  assign bus.shape      = cfg_q[sel].shape;
  assign bus.osc_enable = osc_enable_q;

  assign mix_out   = mix_out_q;
  assign mix_valid = mix_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler with an oscillator stub returning 100*(index+1).
module tb_voice_scheduler;
  import protocol_pkg::*;

  localparam int N  = 8;
  localparam int W  = 24;
  localparam int OW = W + FIXED_POINT;
  localparam int MW = OW + $clog2(N);

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 sample_tick = 1'b0;
  logic signed [MW-1:0] mix_out;
  logic                 mix_valid;
  logic                 overrun;
  logic [N-1:0]         en_mask = '0;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] rst_seen;
  logic [31:0]  freq_seen [N];
  int           lat;
  int           mv_count;

  voice_scheduler_if #(.N_VOICES(N), .WIDTH(W)) bus ();

  voice_scheduler #(.N_VOICES(N), .WIDTH(W), .GRACE(31)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .sample_tick (sample_tick),
    .bus         (bus),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Parked index reads as a silent oscillator.
  always_comb begin
    bus.osc_out     = '0;
    bus.osc_enabled = 1'b0;
    if (bus.index < 4'(N)) begin
      bus.osc_out     = OW'(100 * (int'(bus.index) + 1));
      bus.osc_enabled = en_mask[bus.index[2:0]];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_note(input logic [31:0] f);
    bus.note_valid = 1'b1;
    bus.note_freq  = f;
    bus.note_amp   = W'(f);
    bus.note_shape = WAVE_SAW;
    step(1);
    bus.note_valid = 1'b0;
  endtask

  // Raises a tick and follows the sweep; lat counts edges from the tick edge to mix_valid.
  task automatic do_sweep(input int extra_at);
    rst_seen    = '0;
    lat         = -1;
    sample_tick = 1'b1;
    for (int c = 0; c < 16 && lat < 0; c++) begin
      @(posedge clk);
      #1;
      sample_tick    = (c == extra_at);
      bus.note_valid = 1'b0;
      if (bus.index < 4'(N)) begin
        if (bus.cmds[ENVELOPE_RESET_BIT]) rst_seen[bus.index[2:0]] = 1'b1;
        freq_seen[bus.index[2:0]] = bus.freq;
      end
      if (mix_valid) lat = c;
    end
    sample_tick = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step(2);
    #2 rstn = 1'b1;
    step(1);
  endtask

  initial begin
    bus.note_valid = 1'b0;
    bus.note_freq  = '0;
    bus.note_amp   = '0;
    bus.note_shape = WAVE_SINE;

    // Reset values
    #12;
    check("rst_index", bus.index, 8);
    check("rst_mix_out", mix_out, 0);
    check("rst_mix_valid", mix_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_osc_enable", bus.osc_enable, 0);
    check("rst_cmds", bus.cmds, 0);
    #10 rstn = 1'b1;
    step(1);
    check("osc_enable_after_rst", bus.osc_enable, 1);
    check("ready_idle", bus.note_ready, 1);

    // Plain sweep: 100+200+...+800
    do_sweep(-1);
    check("sweep_latency", lat, 9);
    check("sweep_mix", mix_out, 3600);
    check("sweep_no_resets", rst_seen, 0);
    check("sweep_index_parked", bus.index, 8);
    step(1);
    check("mix_valid_single", mix_valid, 0);

    // Three notes, the last one on the same edge as the tick
    send_note(32'd1000);
    send_note(32'd1001);
    check("ready_before_third", bus.note_ready, 1);
    bus.note_valid = 1'b1;
    bus.note_freq  = 32'd1002;
    bus.note_amp   = W'(1002);
    do_sweep(-1);
    check("alloc_resets", rst_seen, 8'h07);
    check("alloc_freq0", freq_seen[0], 1000);
    check("alloc_freq1", freq_seen[1], 1001);
    check("alloc_freq2", freq_seen[2], 1002);
    check("alloc_latency", lat, 9);
    step(1);
    do_sweep(-1);
    check("resets_cleared", rst_seen, 0);
    step(1);

    // Fill voices 3..7, then steal 0,1,2 and voice 3 while its reset is still pending
    en_mask = 8'hFF;
    for (int i = 0; i < 5; i++) send_note(32'd1003 + 32'(i));
    send_note(32'd2000);
    send_note(32'd2001);
    send_note(32'd2002);
    check("steal_ptr_after3", dut.u_alloc.steal_q, 3);
    send_note(32'd2003);
    check("steal_ptr_after4", dut.u_alloc.steal_q, 4);
    do_sweep(-1);
    check("steal_resets", rst_seen, 8'hFF);
    check("steal_freq0", freq_seen[0], 2000);
    check("steal_freq2", freq_seen[2], 2002);
    check("steal_freq3_overwrite", freq_seen[3], 2003);
    check("steal_freq7", freq_seen[7], 1007);
    step(1);

    // Grace: voice 0 with a silent envelope stays busy for 31 sweeps
    do_reset();
    en_mask = '0;
    send_note(32'd3000);
    for (int s = 0; s < 31; s++) begin
      do_sweep(-1);
      step(1);
    end
    check("grace_busy_31", dut.busy_q[0], 1);
    send_note(32'd3001);
    do_sweep(-1);
    step(1);
    check("grace_skip_busy0", rst_seen, 8'h02);
    check("grace_free_32", dut.busy_q[0], 0);
    send_note(32'd3002);
    do_sweep(-1);
    step(1);
    check("grace_realloc0", rst_seen, 8'h01);
    check("grace_realloc0_freq", freq_seen[0], 3002);

    // Tick during a sweep
    do_sweep(3);
    check("overrun_latency", lat, 9);
    check("overrun_set", overrun, 1);
    check("overrun_mix", mix_out, 3600);
    step(1);
    check("overrun_back_idle", bus.note_ready, 1);
    do_sweep(-1);
    check("overrun_sticky", overrun, 1);
    step(1);

    // Asynchronous reset at index 4
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    step(4);
    check("abort_at_index4", bus.index, 4);
    #2 rstn = 1'b0;
    #1;
    check("abort_index", bus.index, 8);
    check("abort_mix_out", mix_out, 0);
    check("abort_overrun", overrun, 0);
    check("abort_osc_enable", bus.osc_enable, 0);
    check("abort_cmds", bus.cmds, 0);
    check("abort_ready", bus.note_ready, 1);
    mv_count = 0;
    for (int c = 0; c < 14; c++) begin
      if (c == 2) rstn = 1'b1;
      step(1);
      if (mix_valid) mv_count++;
    end
    check("abort_no_mix_valid", mv_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
